// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control FSM for the MIPS-subset datapath.
// Sequences fetch, decode, execute, memory and write-back, plus reset-time $sp init,
// overflow/illegal-opcode exceptions (EPC + vector) and BREAK halt.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   opcode, funct           IR[31:26], IR[5:0]
//   zero, overflow          ALU flags (same cycle)
//   pc_write, ir_write      PC / IR load enables
//   mem_rd, mem_wr, iord    memory strobes, address select (0=PC, 1=ALUOut)
//   reg_write               register file write enable
//   reg_dst_ctrl            write addr: 00=$29, 01=rt, 10=$31, 11=rd
//   mem_to_reg              write data: 00=ALUOut, 01=MDR, 10=PC, 11=SP_INIT
//   alu_src_a               0=PC, 1=A
//   alu_src_b               00=B, 01=4, 10=sext(imm), 11=sext(imm)<<2
//   alu_op                  001=add, 010=sub, 011=and, 100=pass A
//   pc_source               00=ALU result, 01=ALUOut, 10=jump target, 11=exception vector
//   epc_write               EPC <= ALU result
//   halted                  high in HALT
//   state_o                 current state encoding (debug)
module mc_ctrl_fsm #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       iord,
  output logic       reg_write,
  output logic [1:0] reg_dst_ctrl,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       epc_write,
  output logic       halted,
  output logic [4:0] state_o
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;

  typedef enum logic [4:0] {
    ST_RESET    = 5'd0,
    ST_FETCH    = 5'd1,
    ST_DECODE   = 5'd2,
    ST_EXEC_R   = 5'd3,
    ST_WB_R     = 5'd4,
    ST_ADDI_EX  = 5'd5,
    ST_ADDI_WB  = 5'd6,
    ST_MEM_ADDR = 5'd7,
    ST_LW_RD    = 5'd8,
    ST_LW_WB    = 5'd9,
    ST_SW_WR    = 5'd10,
    ST_BEQ      = 5'd11,
    ST_J        = 5'd12,
    ST_JAL      = 5'd13,
    ST_JR       = 5'd14,
    ST_EXC_OVF  = 5'd15,
    ST_EXC_OPC  = 5'd16,
    ST_EXC_JMP  = 5'd17,
    ST_HALT     = 5'd18
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Low until the first clock edge after reset release; keeps RESET outputs quiet while held.
  logic             run_q;
  logic             mem_last;

  assign mem_last = (cnt_q == CNT_LAST);
  assign state_o  = state_q;

  // State, memory-cycle counter and run flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

  // Next-state and Moore output decode; counter restarts at 0 on every state entry.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    iord         = 1'b0;
    reg_write    = 1'b0;
    reg_dst_ctrl = 2'b00;
    mem_to_reg   = 2'b00;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 3'b001;
    pc_source    = 2'b00;
    epc_write    = 1'b0;
    halted       = 1'b0;

    case (state_q)
      ST_RESET: begin
        if (run_q) begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b11;
          state_d    = ST_FETCH;
        end else begin
          alu_op = 3'b000;
        end
      end
      ST_FETCH: begin
        mem_rd = 1'b1;
        if (mem_last) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          state_d   = ST_DECODE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_AND: state_d = ST_EXEC_R;
              FN_JR:                  state_d = ST_JR;
              FN_BREAK:               state_d = ST_HALT;
              default:                state_d = ST_EXC_OPC;
            endcase
          end
          OP_ADDI:      state_d = ST_ADDI_EX;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ:       state_d = ST_BEQ;
          OP_J:         state_d = ST_J;
          OP_JAL:       state_d = ST_JAL;
          default:      state_d = ST_EXC_OPC;
        endcase
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        case (funct)
          FN_SUB:  alu_op = 3'b010;
          FN_AND:  alu_op = 3'b011;
          default: alu_op = 3'b001;
        endcase
        // Only add/sub trap; AND cannot overflow.
        state_d = (overflow && (funct != FN_AND)) ? ST_EXC_OVF : ST_WB_R;
      end
      ST_WB_R: begin
        reg_write    = 1'b1;
        reg_dst_ctrl = 2'b11;
        state_d      = ST_FETCH;
      end
      ST_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = overflow ? ST_EXC_OVF : ST_ADDI_WB;
      end
      ST_ADDI_WB: begin
        reg_write    = 1'b1;
        reg_dst_ctrl = 2'b01;
        state_d      = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? ST_LW_RD : ST_SW_WR;
      end
      ST_LW_RD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        if (mem_last) state_d = ST_LW_WB;
        else          cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_LW_WB: begin
        reg_write    = 1'b1;
        reg_dst_ctrl = 2'b01;
        mem_to_reg   = 2'b01;
        state_d      = ST_FETCH;
      end
      ST_SW_WR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        if (mem_last) state_d = ST_FETCH;
        else          cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        pc_source = 2'b01;
        pc_write  = zero;
        state_d   = ST_FETCH;
      end
      ST_J: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = ST_FETCH;
      end
      ST_JAL: begin
        // PC already holds PC+4 here, which is the link value.
        reg_write    = 1'b1;
        reg_dst_ctrl = 2'b10;
        mem_to_reg   = 2'b10;
        pc_write     = 1'b1;
        pc_source    = 2'b10;
        state_d      = ST_FETCH;
      end
      ST_JR: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b100;
        pc_write  = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_EXC_OVF, ST_EXC_OPC: begin
        // EPC <= PC - 4, the faulting instruction's address.
        alu_src_b = 2'b01;
        alu_op    = 3'b010;
        epc_write = 1'b1;
        state_d   = ST_EXC_JMP;
      end
      ST_EXC_JMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
        state_d   = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: scoreboard bench for mc_ctrl_fsm. The stimulus process issues instructions and
// pushes the expected per-cycle control vectors built from the instruction-level sequencing rules;
// the monitor pops and compares one vector per falling clock edge, and checks that outputs drop
// to zero right after an asynchronous reset assertion.
module tb_mc_ctrl_fsm;

  localparam int unsigned MEM_LAT = 2;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       reg_write;
    logic [1:0] reg_dst_ctrl;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       epc_write;
    logic       halted;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       overflow = 1'b0;
  logic       pc_write, ir_write, mem_rd, mem_wr, iord, reg_write;
  logic [1:0] reg_dst_ctrl, mem_to_reg, alu_src_b, pc_source;
  logic       alu_src_a, epc_write, halted;
  logic [2:0] alu_op;
  logic [4:0] state_dbg;
  ctl_t       act;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .pc_write(pc_write), .ir_write(ir_write), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .iord(iord), .reg_write(reg_write), .reg_dst_ctrl(reg_dst_ctrl),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .epc_write(epc_write), .halted(halted), .state_o(state_dbg)
  );

  assign act = {pc_write, ir_write, mem_rd, mem_wr, iord, reg_write, reg_dst_ctrl, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, pc_source, epc_write, halted};

  ctl_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  ctl_t  mon_e;
  string mon_t;

  // Monitor: reset drops are made while clk is high, clock samples happen at clk falling edges.
  always begin
    @(negedge clk or negedge reset_n);
    if (clk === 1'b1) begin
      #1;
      n_tests++;
      if (act !== ctl_t'(0)) begin
        n_fail++;
        $display("FAIL rst_async: got %05h expected %05h", act, ctl_t'(0));
      end
    end else if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      n_tests++;
      if (act !== mon_e) begin
        n_fail++;
        $display("FAIL %s: got %05h expected %05h (op %02h fn %02h)", mon_t, act, mon_e, opcode, funct);
      end
    end
  end

  function automatic ctl_t base();
    ctl_t v = '0;
    v.alu_op = 3'b001;
    return v;
  endfunction

  task automatic push(input ctl_t v, input string tag);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic push_exc(input string tag);
    ctl_t v;
    v = base(); v.alu_src_b = 2'b01; v.alu_op = 3'b010; v.epc_write = 1'b1; push(v, tag);
    v = base(); v.pc_write = 1'b1; v.pc_source = 2'b11; push(v, "exc_jmp");
  endtask

  // Expected vectors for fetch + decode, then the instruction-specific tail.
  // Returns 1 in is_halt when the instruction is BREAK (HALT is entered, never left).
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input logic ov, output bit is_halt);
    ctl_t v;
    is_halt = 1'b0;
    for (int i = 0; i < int'(MEM_LAT); i++) begin
      v = base(); v.mem_rd = 1'b1;
      if (i == int'(MEM_LAT) - 1) begin
        v.ir_write = 1'b1; v.pc_write = 1'b1; v.alu_src_b = 2'b01;
      end
      push(v, "fetch");
    end
    v = base(); v.alu_src_b = 2'b11; push(v, "decode");
    case (op)
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24) begin
          v = base(); v.alu_src_a = 1'b1;
          v.alu_op = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
          push(v, "exec_r");
          if (ov && fn != 6'h24) push_exc("exc_ovf");
          else begin
            v = base(); v.reg_write = 1'b1; v.reg_dst_ctrl = 2'b11; push(v, "wb_r");
          end
        end else if (fn == 6'h08) begin
          v = base(); v.alu_src_a = 1'b1; v.alu_op = 3'b100; v.pc_write = 1'b1; push(v, "jr");
        end else if (fn == 6'h0D) begin
          is_halt = 1'b1;
          for (int i = 0; i < 6; i++) begin
            v = base(); v.halted = 1'b1; push(v, "halt");
          end
        end else push_exc("exc_opc_funct");
      end
      6'h08: begin
        v = base(); v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; push(v, "addi_ex");
        if (ov) push_exc("exc_ovf_addi");
        else begin
          v = base(); v.reg_write = 1'b1; v.reg_dst_ctrl = 2'b01; push(v, "addi_wb");
        end
      end
      6'h23, 6'h2B: begin
        v = base(); v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; push(v, "mem_addr");
        for (int i = 0; i < int'(MEM_LAT); i++) begin
          v = base(); v.iord = 1'b1;
          if (op == 6'h23) v.mem_rd = 1'b1; else v.mem_wr = 1'b1;
          push(v, (op == 6'h23) ? "lw_rd" : "sw_wr");
        end
        if (op == 6'h23) begin
          v = base(); v.reg_write = 1'b1; v.reg_dst_ctrl = 2'b01; v.mem_to_reg = 2'b01;
          push(v, "lw_wb");
        end
      end
      6'h04: begin
        v = base(); v.alu_src_a = 1'b1; v.alu_op = 3'b010; v.pc_source = 2'b01; v.pc_write = z;
        push(v, "beq");
      end
      6'h02: begin
        v = base(); v.pc_write = 1'b1; v.pc_source = 2'b10; push(v, "j");
      end
      6'h03: begin
        v = base(); v.reg_write = 1'b1; v.reg_dst_ctrl = 2'b10; v.mem_to_reg = 2'b10;
        v.pc_write = 1'b1; v.pc_source = 2'b10; push(v, "jal");
      end
      default: push_exc("exc_opc");
    endcase
  endtask

  // Hold reset 3 cycles, release, expect the idle cycle then one RESET ($sp init) cycle.
  task automatic do_reset();
    ctl_t v;
    reset_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push(ctl_t'(0), "rst_low");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    push(ctl_t'(0), "rst_release");
    v = base(); v.reg_write = 1'b1; v.mem_to_reg = 2'b11; push(v, "reset_sp_init");
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Called one time unit after the edge that starts a FETCH; returns at the next FETCH start.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
    int n0;
    int n;
    bit hlt;
    n0 = exp_q.size();
    opcode = op; funct = fn; zero = z; overflow = ov;
    push_instr(op, fn, z, ov, hlt);
    n = exp_q.size() - n0;
    repeat (n) @(posedge clk);
    #1;
    if (hlt) do_reset();
  endtask

  // lw interrupted by reset during its first LW_RD cycle.
  task automatic lw_with_reset();
    ctl_t v;
    opcode = 6'h23; funct = 6'h00; zero = 1'b0; overflow = 1'b0;
    for (int i = 0; i < int'(MEM_LAT); i++) begin
      v = base(); v.mem_rd = 1'b1;
      if (i == int'(MEM_LAT) - 1) begin
        v.ir_write = 1'b1; v.pc_write = 1'b1; v.alu_src_b = 2'b01;
      end
      push(v, "lwr_fetch");
    end
    v = base(); v.alu_src_b = 2'b11; push(v, "lwr_decode");
    v = base(); v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; push(v, "lwr_mem_addr");
    repeat (int'(MEM_LAT) + 2) @(posedge clk);
    #2;
    do_reset();
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    int         pick;
    do_reset();
    issue(6'h00, 6'h20, 1'b0, 1'b0);  // add
    issue(6'h00, 6'h20, 1'b0, 1'b1);  // add overflow
    issue(6'h00, 6'h22, 1'b0, 1'b1);  // sub overflow
    issue(6'h00, 6'h24, 1'b0, 1'b1);  // and ignores overflow
    issue(6'h23, 6'h00, 1'b0, 1'b0);  // lw
    issue(6'h2B, 6'h00, 1'b0, 1'b0);  // sw
    issue(6'h03, 6'h00, 1'b0, 1'b0);  // jal
    issue(6'h04, 6'h00, 1'b0, 1'b0);  // beq not taken
    issue(6'h04, 6'h00, 1'b1, 1'b0);  // beq taken
    issue(6'h02, 6'h00, 1'b0, 1'b0);  // j
    issue(6'h08, 6'h00, 1'b0, 1'b1);  // addi overflow
    issue(6'h08, 6'h00, 1'b0, 1'b0);  // addi
    issue(6'h00, 6'h08, 1'b0, 1'b0);  // jr
    issue(6'h3F, 6'h00, 1'b0, 1'b0);  // illegal opcode
    issue(6'h00, 6'h21, 1'b0, 1'b0);  // illegal funct
    lw_with_reset();
    issue(6'h00, 6'h20, 1'b0, 1'b0);  // resumes cleanly after reset
    issue(6'h00, 6'h0D, 1'b0, 1'b0);  // break -> halt, then reset

    for (int k = 0; k < 150; k++) begin
      pick = int'($urandom_range(0, 11));
      fn   = 6'($urandom_range(0, 63));
      op   = 6'h00;
      case (pick)
        0: fn = 6'h20;
        1: fn = 6'h22;
        2: fn = 6'h24;
        3: fn = 6'h08;
        4: ;
        5: op = 6'h08;
        6: op = 6'h23;
        7: op = 6'h2B;
        8: op = 6'h04;
        9: op = 6'h02;
        10: op = 6'h03;
        default: op = 6'($urandom_range(0, 63));
      endcase
      if (k == 75) issue(6'h00, 6'h0D, 1'b0, 1'b0);
      issue(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
